branch_predictor_unit: RTL and testbench
========================================

Name: branch_predictor_unit

Overview:
Parametrised branch predictor for the pipelined RISC-V core. It combines a direct-mapped tagged BTB with a pattern history table (PHT) of saturating counters, selectable between bimodal and gshare indexing. IF reads it combinationally every cycle; EX writes resolved branch outcomes one per cycle. It also keeps branch/mispredict statistics counters for test reporting.

Parameters:
ENTRIES, 64, BTB and PHT entry count; power of two, ≥4; IDX = log2(ENTRIES)
PC_W, 12, PC width in bytes-address bits; PC_W ≥ IDX+3
CTR_W, 2, PHT counter width (1..4)
GHR_W, 6, global history length (1..IDX)
MODE, 0, 0 = bimodal, 1 = gshare

Ports:
CLK  in  1  clock, all state updates on posedge
RSTn  in  1  synchronous, active-low reset
lk_pc  in  PC_W  fetch PC being looked up (IF stage)
pred_hit  out  1  BTB valid and tag match for lk_pc
pred_taken  out  1  predicted taken (pred_hit & counter MSB)
pred_next_pc  out  PC_W  pred_taken ? BTB target : lk_pc+4 (mod 2^PC_W)
pred_ghr  out  GHR_W  current GHR, carried down the pipe with the instruction
up_valid  in  1  resolved conditional branch in EX this cycle
up_pc  in  PC_W  PC of resolved branch
up_taken  in  1  actual outcome
up_target  in  PC_W  actual taken target
up_ghr  in  GHR_W  pred_ghr snapshot captured at fetch of this branch
up_mispred  in  1  EX detected a misprediction (stats only)
BR_CNT  out  32  resolved branches
MISS_CNT  out  32  mispredictions

Behaviour:
- Index/tag: idx = pc[IDX+1:2]; tag = pc[PC_W-1:IDX+2]. PHT index: MODE 0 → idx; MODE 1 → idx XOR zero-extended GHR (lookup uses the live GHR, update uses up_ghr).
- Lookup is purely combinational from lk_pc and the current state; zero latency. pred_next_pc wraps modulo 2^PC_W.
- Update, posedge with RSTn=1 and up_valid=1:
  - PHT counter saturating +1 if up_taken, −1 otherwise; holds at 0 and at 2^CTR_W−1.
  - When up_taken: BTB[idx] ← {valid=1, tag, up_target}, replacing any aliasing entry. A not-taken update leaves the BTB unchanged.
  - GHR ← {GHR[GHR_W-2:0], up_taken}. The GHR is non-speculative and needs no recovery path. In MODE 0 it still shifts but is unused for indexing.
  - BR_CNT +1; if up_mispred, MISS_CNT +1. Both saturate at 0xFFFFFFFF.
- up_valid=0: no state change; up_mispred is ignored.
- Read-during-write: a lookup in the same cycle as an update to the same entry returns the pre-update values. The new values are visible the next cycle; there is no bypass.
- PHT entries are untagged, so aliasing PCs share counters. pred_taken is forced 0 whenever pred_hit=0.
- Reset, posedge with RSTn=0:
  - All BTB valid bits ← 0; tag and target arrays are don't-care.
  - All PHT counters ← 2^(CTR_W-1)−1 (weakly not-taken; 1 for CTR_W=2).
  - GHR ← 0; BR_CNT and MISS_CNT ← 0.
  - Any update presented in the same cycle is dropped.
  - Effect after reset: pred_hit=0, pred_taken=0, pred_next_pc=lk_pc+4, pred_ghr=0.
- Reset asserted mid-stream behaves identically to power-on reset; there is no partial state.
- No X on any output after the first reset edge, for any lk_pc.

Test Plan:
1. Defaults (ENTRIES=64, PC_W=12, MODE=0); reset, then lk_pc=0x040 → pred_hit=0, pred_taken=0, pred_next_pc=0x044, pred_ghr=0, BR_CNT=0.
2. Update pc 0x040 taken, target 0x100 → next cycle lk_pc=0x040 gives hit=1, counter 2, taken=1, next_pc=0x100, BR_CNT=1, GHR=0x01. Then two not-taken updates → counter 0, hit=1, taken=0, next_pc=0x044.
3. Saturation: 5 taken updates on 0x040 → counter 3; one not-taken → 2, still taken. 6 not-taken → counter 0; one taken → 1, not taken.
4. Alias: 0x040 trained taken to 0x100, then update 0x140 taken to 0x200 (same idx 0x10, tag 1 vs 0) → lk_pc=0x040 hit=0, next_pc=0x044; lk_pc=0x140 hit=1, next_pc=0x200.
5. Same-cycle: lk_pc=0x080 while updating 0x080 taken to 0x300 → that cycle hit=0, next_pc=0x084; next cycle hit=1, next_pc=0x300. Updates with up_mispred=1 ×3 → MISS_CNT=3.
6. MODE=1, GHR_W=6: three taken updates → pred_ghr=0x07. Train pc 0x040 with up_ghr=0x07 → PHT index 0x17 changes, not index 0x10. Then RSTn=0 for one cycle with up_valid=1 → update dropped; hit=0, pred_ghr=0, BR_CNT=0, MISS_CNT=0.

Source files
------------

// File: rtl/branch_predictor_unit.sv
// Branch predictor: direct-mapped tagged BTB plus a PHT of saturating counters,
// bimodal or gshare indexed, with resolved-branch and mispredict statistics.
module branch_predictor_unit #(
    parameter int ENTRIES = 64,
    parameter int PC_W    = 12,
    parameter int CTR_W   = 2,
    parameter int GHR_W   = 6,
    parameter int MODE    = 0
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [PC_W-1:0]   lk_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_next_pc,
    output logic [GHR_W-1:0]  pred_ghr,
    input  logic              up_valid,
    input  logic [PC_W-1:0]   up_pc,
    input  logic              up_taken,
    input  logic [PC_W-1:0]   up_target,
    input  logic [GHR_W-1:0]  up_ghr,
    input  logic              up_mispred,
    output logic [31:0]       BR_CNT,
    output logic [31:0]       MISS_CNT
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX - 2;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;

    typedef logic [IDX-1:0] idx_t;

    function automatic idx_t pht_index(input idx_t idx, input logic [GHR_W-1:0] ghr);
        if (MODE == 1) return idx ^ IDX'(ghr);
        else           return idx;
    endfunction

    logic              btb_valid_q [ENTRIES];
    logic [TAG_W-1:0]  btb_tag_q   [ENTRIES];
    logic [PC_W-1:0]   btb_tgt_q   [ENTRIES];
    logic [CTR_W-1:0]  pht_q       [ENTRIES];
    logic [GHR_W-1:0]  ghr_q, ghr_d;
    logic [31:0]       br_cnt_q, br_cnt_d;
    logic [31:0]       miss_cnt_q, miss_cnt_d;

    idx_t              lk_idx, up_idx, up_pht_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag;
    logic [CTR_W-1:0]  ctr_cur, ctr_d;
    logic              unused_pc_bits;

    assign lk_idx         = lk_pc[IDX+1:2];
    assign lk_tag         = lk_pc[PC_W-1:IDX+2];
    assign up_idx         = up_pc[IDX+1:2];
    assign up_tag         = up_pc[PC_W-1:IDX+2];
    assign up_pht_idx     = pht_index(up_idx, up_ghr);
    assign unused_pc_bits = ^{lk_pc[1:0], up_pc[1:0]};

    // Lookup is zero latency; pre-update state is seen during a same-entry write.
    assign pred_hit     = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    assign pred_taken   = pred_hit && pht_q[pht_index(lk_idx, ghr_q)][CTR_W-1];
    assign pred_next_pc = pred_taken ? btb_tgt_q[lk_idx] : lk_pc + PC_W'(4);
    assign pred_ghr     = ghr_q;
    assign BR_CNT       = br_cnt_q;
    assign MISS_CNT     = miss_cnt_q;

    assign ctr_cur = pht_q[up_pht_idx];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ctr_d      = ctr_cur;
        ghr_d      = GHR_W'({ghr_q, up_taken});
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (up_taken && ctr_cur != CTR_MAX)
            ctr_d = ctr_cur + CTR_W'(1);
        else if (!up_taken && ctr_cur != '0)
            ctr_d = ctr_cur - CTR_W'(1);
        if (br_cnt_q != 32'hFFFF_FFFF)
            br_cnt_d = br_cnt_q + 32'd1;
        if (miss_cnt_q != 32'hFFFF_FFFF)
            miss_cnt_d = miss_cnt_q + 32'd1;
    end

    // NOTE: state registers use non-blocking assignments so all updates commit together.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid_q[i] <= 1'b0;
                pht_q[i]       <= CTR_INIT;
            end
            ghr_q      <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else if (up_valid) begin
            pht_q[up_pht_idx] <= ctr_d;
            if (up_taken)
                btb_valid_q[up_idx] <= 1'b1;
            ghr_q    <= ghr_d;
            br_cnt_q <= br_cnt_d;
            if (up_mispred)
                miss_cnt_q <= miss_cnt_d;
        end
    end

    // NOTE: tag/target payload is deliberately not reset; the valid bits gate its use.
    always_ff @(posedge CLK) begin
        if (RSTn && up_valid && up_taken) begin
            btb_tag_q[up_idx] <= up_tag;
            btb_tgt_q[up_idx] <= up_target;
        end
    end

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Self-checking bench: a bimodal and a gshare instance share stimulus and are
// compared against an array-based reference model plus directed expectations.
module tb_branch_predictor_unit;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [11:0] lk_pc;
    logic        up_valid, up_taken, up_mispred;
    logic [11:0] up_pc, up_target;
    logic [5:0]  up_ghr;

    logic        hit0, tk0, hit1, tk1;
    logic [11:0] nx0, nx1;
    logic [5:0]  ghr0, ghr1;
    logic [31:0] br0, miss0, br1, miss1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    bit     m_valid [64];
    int     m_tag   [64];
    int     m_tgt   [64];
    int     m_pht   [2][64];
    int     m_ghr;
    longint m_br, m_miss;

    always #5 CLK = ~CLK;

    branch_predictor_unit #(.MODE(0)) dut0 (
        .CLK(CLK), .RSTn(RSTn), .lk_pc(lk_pc),
        .pred_hit(hit0), .pred_taken(tk0), .pred_next_pc(nx0), .pred_ghr(ghr0),
        .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_target(up_target),
        .up_ghr(up_ghr), .up_mispred(up_mispred), .BR_CNT(br0), .MISS_CNT(miss0)
    );

    branch_predictor_unit #(.MODE(1)) dut1 (
        .CLK(CLK), .RSTn(RSTn), .lk_pc(lk_pc),
        .pred_hit(hit1), .pred_taken(tk1), .pred_next_pc(nx1), .pred_ghr(ghr1),
        .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_target(up_target),
        .up_ghr(up_ghr), .up_mispred(up_mispred), .BR_CNT(br1), .MISS_CNT(miss1)
    );

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i]  = 1'b0;
            m_pht[0][i] = 1;
            m_pht[1][i] = 1;
        end
        m_ghr  = 0;
        m_br   = 0;
        m_miss = 0;
    endfunction

    function automatic void model_update();
        int i, pi, c;
        if (!RSTn) begin
            model_reset();
            return;
        end
        if (!up_valid) return;
        i = (int'(up_pc) / 4) % 64;
        for (int m = 0; m < 2; m++) begin
            pi = (m == 1) ? (i ^ int'(up_ghr)) : i;
            c  = m_pht[m][pi] + (up_taken ? 1 : -1);
            m_pht[m][pi] = (c > 3) ? 3 : ((c < 0) ? 0 : c);
        end
        if (up_taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = int'(up_pc) / 256;
            m_tgt[i]   = int'(up_target);
        end
        m_ghr = (m_ghr * 2 + int'(up_taken)) % 64;
        if (m_br < 64'hFFFF_FFFF) m_br++;
        if (up_mispred && m_miss < 64'hFFFF_FFFF) m_miss++;
    endfunction

    function automatic void model_pred(input int pc, input int mode,
                                       output bit hit, output bit taken, output int nxt);
        int i, pi;
        i     = (pc / 4) % 64;
        pi    = (mode == 1) ? (i ^ m_ghr) : i;
        hit   = m_valid[i] && (m_tag[i] == pc / 256);
        taken = hit && (m_pht[mode][pi] >= 2);
        nxt   = taken ? m_tgt[i] : (pc + 4) % 4096;
    endfunction

    // Advance one clock; the model sees exactly what the DUT sampled at the edge.
    task automatic cycle();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic drive_up(input logic [11:0] pc, input logic taken,
                            input logic [11:0] tgt, input logic mispred);
        up_valid   = 1'b1;
        up_pc      = pc;
        up_taken   = taken;
        up_target  = tgt;
        up_ghr     = 6'(m_ghr);
        up_mispred = mispred;
    endtask

    task automatic idle();
        up_valid   = 1'b0;
        up_mispred = 1'b0;
    endtask

    task automatic update(input logic [11:0] pc, input logic taken,
                          input logic [11:0] tgt, input logic mispred);
        drive_up(pc, taken, tgt, mispred);
        cycle();
        idle();
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        cycle();
        RSTn = 1'b1;
    endtask

    task automatic test_reset();
        RSTn = 1'b0; lk_pc = 12'h040; idle();
        up_pc = '0; up_taken = 0; up_target = '0; up_ghr = '0;
        cycle(); cycle();
        RSTn = 1'b1;
        @(negedge CLK);
        n_tests++;
        if ({hit0, tk0, nx0} !== {1'b0, 1'b0, 12'h044}) begin
            n_fail++; $display("FAIL reset_pred: got hit/tk/nx=%h exp %h", {hit0, tk0, nx0}, {2'b00, 12'h044});
        end
        n_tests++;
        if ({ghr0, br0, miss0, ghr1, br1, miss1} !== '0) begin
            n_fail++; $display("FAIL reset_state: ghr0=%h br0=%0d miss0=%0d ghr1=%h br1=%0d miss1=%0d exp all 0",
                               ghr0, br0, miss0, ghr1, br1, miss1);
        end
        cycle();
    endtask

    task automatic test_basic();
        update(12'h040, 1'b1, 12'h100, 1'b0);
        @(negedge CLK);
        n_tests++;
        if ({hit0, tk0, nx0} !== {1'b1, 1'b1, 12'h100}) begin
            n_fail++; $display("FAIL basic_taken: got %h exp %h", {hit0, tk0, nx0}, {2'b11, 12'h100});
        end
        n_tests++;
        if (br0 !== 32'd1 || ghr0 !== 6'h01) begin
            n_fail++; $display("FAIL basic_cnt: br=%0d ghr=%h exp br=1 ghr=01", br0, ghr0);
        end
        cycle();
        update(12'h040, 1'b0, 12'h000, 1'b0);
        update(12'h040, 1'b0, 12'h000, 1'b0);
        @(negedge CLK);
        n_tests++;
        if ({hit0, tk0, nx0} !== {1'b1, 1'b0, 12'h044}) begin
            n_fail++; $display("FAIL basic_nottaken: got %h exp %h", {hit0, tk0, nx0}, {2'b10, 12'h044});
        end
        cycle();
    endtask

    task automatic test_saturation();
        lk_pc = 12'h040;
        repeat (5) update(12'h040, 1'b1, 12'h100, 1'b0);
        update(12'h040, 1'b0, 12'h000, 1'b0);
        @(negedge CLK);
        n_tests++;
        if ({hit0, tk0, nx0} !== {1'b1, 1'b1, 12'h100}) begin
            n_fail++; $display("FAIL sat_high: got %h exp %h", {hit0, tk0, nx0}, {2'b11, 12'h100});
        end
        cycle();
        repeat (6) update(12'h040, 1'b0, 12'h000, 1'b0);
        update(12'h040, 1'b1, 12'h100, 1'b0);
        @(negedge CLK);
        n_tests++;
        if ({hit0, tk0, nx0} !== {1'b1, 1'b0, 12'h044}) begin
            n_fail++; $display("FAIL sat_low: got %h exp %h", {hit0, tk0, nx0}, {2'b10, 12'h044});
        end
        cycle();
    endtask

    task automatic test_alias();
        update(12'h040, 1'b1, 12'h100, 1'b0);
        update(12'h140, 1'b1, 12'h200, 1'b0);
        lk_pc = 12'h040;
        @(negedge CLK);
        n_tests++;
        if ({hit0, tk0, nx0} !== {1'b0, 1'b0, 12'h044}) begin
            n_fail++; $display("FAIL alias_old: got %h exp %h", {hit0, tk0, nx0}, {2'b00, 12'h044});
        end
        lk_pc = 12'h140;
        #1;
        n_tests++;
        if ({hit0, tk0, nx0} !== {1'b1, 1'b1, 12'h200}) begin
            n_fail++; $display("FAIL alias_new: got %h exp %h", {hit0, tk0, nx0}, {2'b11, 12'h200});
        end
        cycle();
    endtask

    task automatic test_same_cycle();
        lk_pc = 12'h080;
        drive_up(12'h080, 1'b1, 12'h300, 1'b0);
        @(negedge CLK);
        n_tests++;
        if ({hit0, tk0, nx0} !== {1'b0, 1'b0, 12'h084}) begin
            n_fail++; $display("FAIL rdw_same: got %h exp %h", {hit0, tk0, nx0}, {2'b00, 12'h084});
        end
        cycle();
        idle();
        @(negedge CLK);
        n_tests++;
        if ({hit0, tk0, nx0} !== {1'b1, 1'b1, 12'h300}) begin
            n_fail++; $display("FAIL rdw_next: got %h exp %h", {hit0, tk0, nx0}, {2'b11, 12'h300});
        end
        cycle();
        repeat (3) update(12'h0C0, 1'b0, 12'h000, 1'b1);
        up_mispred = 1'b1;  // ignored while up_valid is low
        cycle();
        idle();
        @(negedge CLK);
        n_tests++;
        if (miss0 !== 32'd3 || br0 !== m_br[31:0]) begin
            n_fail++; $display("FAIL miss_cnt: miss=%0d br=%0d exp miss=3 br=%0d", miss0, br0, m_br);
        end
        cycle();
    endtask

    task automatic test_gshare();
        do_reset();
        repeat (3) update(12'h800, 1'b1, 12'h010, 1'b0);
        @(negedge CLK);
        n_tests++;
        if (ghr1 !== 6'h07) begin
            n_fail++; $display("FAIL gshare_ghr: got %h exp 07", ghr1);
        end
        cycle();
        drive_up(12'h040, 1'b1, 12'h100, 1'b0);
        up_ghr = 6'h07;
        cycle();
        idle();
        lk_pc = 12'h040;
        @(negedge CLK);
        // Live GHR is now 0x0F: gshare reads entry 0x1F (still weak), bimodal reads 0x10.
        n_tests++;
        if ({hit1, tk1, nx1} !== {1'b1, 1'b0, 12'h044}) begin
            n_fail++; $display("FAIL gshare_pred: got %h exp %h", {hit1, tk1, nx1}, {2'b10, 12'h044});
        end
        n_tests++;
        if ({hit0, tk0, nx0} !== {1'b1, 1'b1, 12'h100}) begin
            n_fail++; $display("FAIL bimodal_pred: got %h exp %h", {hit0, tk0, nx0}, {2'b11, 12'h100});
        end
        cycle();
        RSTn = 1'b0;
        drive_up(12'h040, 1'b1, 12'h100, 1'b1);
        cycle();
        RSTn = 1'b1;
        idle();
        @(negedge CLK);
        n_tests++;
        if ({hit0, hit1, ghr0, ghr1, br0, br1, miss0, miss1} !== '0) begin
            n_fail++; $display("FAIL reset_drop: hit=%b%b ghr=%h/%h br=%0d/%0d miss=%0d/%0d exp all 0",
                               hit0, hit1, ghr0, ghr1, br0, br1, miss0, miss1);
        end
        cycle();
    endtask

    task automatic test_random();
        bit e_hit, e_tk;
        int e_nx;
        logic [11:0] pc;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            RSTn = ($urandom_range(0, 79) != 0);
            pc = 12'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
            drive_up(pc, 1'($urandom), 12'($urandom), 1'($urandom));
            up_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) up_ghr = 6'($urandom);
            lk_pc = ($urandom_range(0, 2) == 0) ? pc
                  : 12'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
            @(negedge CLK);
            model_pred(int'(lk_pc), 0, e_hit, e_tk, e_nx);
            n_tests++;
            if ({hit0, tk0, nx0, ghr0, br0, miss0} !== {e_hit, e_tk, 12'(e_nx), 6'(m_ghr), m_br[31:0], m_miss[31:0]}) begin
                n_fail++; $display("FAIL rand_bimodal[%0d]: got hit=%b tk=%b nx=%h ghr=%h br=%0d miss=%0d exp %b %b %h %h %0d %0d",
                                   n, hit0, tk0, nx0, ghr0, br0, miss0, e_hit, e_tk, e_nx, m_ghr, m_br, m_miss);
            end
            model_pred(int'(lk_pc), 1, e_hit, e_tk, e_nx);
            n_tests++;
            if ({hit1, tk1, nx1, ghr1, br1, miss1} !== {e_hit, e_tk, 12'(e_nx), 6'(m_ghr), m_br[31:0], m_miss[31:0]}) begin
                n_fail++; $display("FAIL rand_gshare[%0d]: got hit=%b tk=%b nx=%h ghr=%h br=%0d miss=%0d exp %b %b %h %h %0d %0d",
                                   n, hit1, tk1, nx1, ghr1, br1, miss1, e_hit, e_tk, e_nx, m_ghr, m_br, m_miss);
            end
            cycle();
        end
        RSTn = 1'b1;
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_saturation();
        test_alias();
        test_same_cycle();
        test_gshare();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
